// File: rtl/fp_add_normalize_round_pkg.sv
// Shared single-precision constants, FSM encoding and result packing for the
// post-adder normalize/round stage.
package fp_add_normalize_round_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 24;
  localparam int unsigned FRAC_W = MAN_W - 1;
  localparam int unsigned RES_W  = EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] EXP_MAX   = {EXP_W{1'b1}};
  localparam logic [MAN_W-1:0] MANT_ONE  = {1'b1, {FRAC_W{1'b0}}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;

  function automatic fp_word_t fp_pack(input logic sign,
                                       input logic [EXP_W-1:0] exp,
                                       input logic [FRAC_W-1:0] frac);
    fp_word_t w;
    w.sign = sign;
    w.exp  = exp;
    w.frac = frac;
    return w;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even incrementer: adds one ulp when guard is set and the
// remainder is above half or the mantissa is odd.
module fp_round_rne
  import fp_add_normalize_round_pkg::*;
(
  input  logic [MAN_W-1:0] mant,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [MAN_W-1:0] mant_rounded,
  output logic             carry,
  output logic             inexact
);

  logic round_up;

  assign round_up = g & (r | s | mant[0]);
  assign inexact  = g | r | s;

  ripple_carry_adder #(
    .W(MAN_W)
  ) u_inc (
    .a   (mant),
    .b   ({MAN_W{1'b0}}),
    .cin (round_up),
    .sum (mant_rounded),
    .cout(carry)
  );

endmodule

// File: rtl/ripple_carry_adder.sv
// Generic ripple-carry adder, sum = a + b + cin.
module ripple_carry_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/fp_add_normalize_round.sv
// Post-adder stage of the binary32 add/sub path: iterative normalize, RNE
// round and pack behind a valid/ready handshake; subnormals flush to zero.
module fp_add_normalize_round
  import fp_add_normalize_round_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_mant,
  input  logic             in_cout,
  input  logic [2:0]       in_grs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_inexact
);

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] mant_q, mant_d;
  logic             cout_q, cout_d;
  logic             g_q, g_d, r_q, r_d, s_q, s_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
  logic             valid_q, valid_d, ready_q, ready_d;

  logic [EXP_W-1:0] exp_inc, exp_dec;
  logic [MAN_W-1:0] rnd_mant;
  logic             rnd_carry, rnd_inexact;

  assign exp_inc = exp_q + EXP_W'(1);
  assign exp_dec = exp_q - EXP_W'(1);

  fp_round_rne u_round (
    .mant        (mant_q),
    .g           (g_q),
    .r           (r_q),
    .s           (s_q),
    .mant_rounded(rnd_mant),
    .carry       (rnd_carry),
    .inexact     (rnd_inexact)
  );

  // Next-state and datapath: one normalization action per NORM cycle.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    cout_d   = cout_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
          cout_d  = in_cout;
          g_d     = in_grs[2];
          r_d     = in_grs[1];
          s_d     = in_grs[0];
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inx_d   = 1'b0;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (exp_q == EXP_MAX) begin
          result_d = fp_pack(sign_q, exp_q, mant_q[FRAC_W-1:0]);
          state_d  = ST_OUT;
        end else if ((exp_q == '0) ||
                     (!cout_q && (mant_q == '0) && !g_q && !r_q && !s_q)) begin
          result_d = '0;
          unf_d    = (exp_q == '0) && (mant_q != '0);
          state_d  = ST_OUT;
        end else if (cout_q) begin
          mant_d = {1'b1, mant_q[MAN_W-1:1]};
          g_d    = mant_q[0];
          r_d    = g_q;
          s_d    = r_q | s_q;
          cout_d = 1'b0;
          exp_d  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_d = fp_pack(sign_q, EXP_MAX, '0);
            ovf_d    = 1'b1;
            state_d  = ST_OUT;
          end else begin
            state_d  = ST_ROUND;
          end
        end else if (mant_q[MAN_W-1]) begin
          state_d = ST_ROUND;
        end else if (exp_q == EXP_W'(1)) begin
          result_d = fp_pack(sign_q, '0, '0);
          unf_d    = 1'b1;
          state_d  = ST_OUT;
        end else begin
          mant_d = {mant_q[MAN_W-2:0], g_q};
          g_d    = r_q;
          r_d    = s_q;
          exp_d  = exp_dec;
        end
      end

      ST_ROUND: begin
        inx_d   = rnd_inexact;
        state_d = ST_OUT;
        // A wrap from all-ones renormalizes to 1.0 with the next exponent.
        if (rnd_carry) begin
          mant_d = MANT_ONE;
          exp_d  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_d = fp_pack(sign_q, EXP_MAX, '0);
            ovf_d    = 1'b1;
          end else begin
            result_d = fp_pack(sign_q, exp_inc, '0);
          end
        end else begin
          mant_d   = rnd_mant;
          result_d = fp_pack(sign_q, exp_q, rnd_mant[FRAC_W-1:0]);
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_OUT);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      cout_q   <= 1'b0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      cout_q   <= cout_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready      = ready_q;
  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_add_normalize_round.sv
// Directed bench for fp_add_normalize_round: results, flags, latency,
// back-pressure hold and mid-operation reset.
module tb_fp_add_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic        in_cout;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_normalize_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .in_cout      (in_cout),
    .in_grs       (in_grs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_inexact  (out_inexact)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one operand, wait (bounded) for the result, check value, flags and latency.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [23:0] m, input logic c, input logic [2:0] grs,
                        input logic [31:0] x_res, input int x_lat, input logic [2:0] x_flags);
    int   lat;
    logic busy_ready;
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_cout  = c;
    in_grs   = grs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    lat        = 0;
    busy_ready = 1'b0;
    while (!out_valid && lat < 60) begin
      busy_ready |= in_ready;
      @(posedge clk); #1; lat++;
    end
    busy_ready |= in_ready;
    chk({tag, "_latency"}, 32'(lat), 32'(x_lat));
    chk({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
    chk({tag, "_result"}, out_result, x_res);
    chk({tag, "_flags"}, 32'({out_overflow, out_underflow, out_inexact}), 32'(x_flags));
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
    end
  endtask

  logic [31:0] held;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_cout   = 1'b0;
    in_grs    = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_valid_ready", 32'({out_valid, in_ready}), 32'b01);
    chk("reset_result", out_result, 32'h0);
    chk("reset_flags", 32'({out_overflow, out_underflow, out_inexact}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // flags order {overflow, underflow, inexact}
    run_op("normalized",   1'b0, 8'h7F, 24'hC00000, 1'b0, 3'b000, 32'h3FC00000, 2,  3'b000);
    run_op("carry_out",    1'b0, 8'h7F, 24'h000000, 1'b1, 3'b000, 32'h40000000, 2,  3'b000);
    run_op("cancel_23",    1'b0, 8'h7F, 24'h000001, 1'b0, 3'b000, 32'h34000000, 25, 3'b000);
    run_op("tie_carry",    1'b0, 8'h7F, 24'hFFFFFF, 1'b0, 3'b100, 32'h40000000, 2,  3'b001);
    run_op("tie_even",     1'b0, 8'h7F, 24'hFFFFFE, 1'b0, 3'b100, 32'h3FFFFFFE, 2,  3'b001);
    run_op("overflow",     1'b1, 8'hFE, 24'h800000, 1'b1, 3'b000, 32'hFF800000, 1,  3'b100);
    run_op("underflow",    1'b0, 8'h02, 24'h000010, 1'b0, 3'b000, 32'h00000000, 2,  3'b010);
    run_op("special_inf",  1'b0, 8'hFF, 24'h800000, 1'b0, 3'b000, 32'h7F800000, 1,  3'b000);
    run_op("exact_zero",   1'b1, 8'h7F, 24'h000000, 1'b0, 3'b000, 32'h00000000, 1,  3'b000);
    run_op("exp_zero",     1'b0, 8'h00, 24'h400000, 1'b0, 3'b000, 32'h00000000, 1,  3'b010);
    run_op("round_odd",    1'b0, 8'h7F, 24'h800001, 1'b0, 3'b100, 32'h3F800002, 2,  3'b001);
    run_op("sticky_only",  1'b0, 8'h7F, 24'h800000, 1'b0, 3'b001, 32'h3F800000, 2,  3'b001);
    run_op("carry_round",  1'b0, 8'h7F, 24'h000001, 1'b1, 3'b100, 32'h40000001, 2,  3'b001);
    run_op("round_ovf",    1'b1, 8'hFE, 24'hFFFFFF, 1'b0, 3'b110, 32'hFF800000, 2,  3'b101);

    // Back-pressure: result and flags must hold while out_ready is low.
    out_ready = 1'b0;
    run_op("hold", 1'b1, 8'h7F, 24'hC00000, 1'b0, 3'b001, 32'hBFC00000, 2, 3'b001);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_result", out_result, held);
      chk("hold_valid_ready", 32'({out_valid, in_ready, out_inexact}), 32'b101);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 32'({out_valid, in_ready}), 32'b01);

    // Reset in the middle of a long normalization discards the operation.
    in_sign  = 1'b0;
    in_exp   = 8'h7F;
    in_mant  = 24'h000001;
    in_cout  = 1'b0;
    in_grs   = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("mid_norm_busy", 32'({out_valid, in_ready}), 32'b00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({out_valid, out_overflow, out_underflow, out_inexact}), 32'h0);
    chk("mid_reset_result", out_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'({out_valid, in_ready}), 32'b01);
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("post_reset_no_result", 32'(out_valid), 32'd0);
    run_op("after_reset", 1'b0, 8'h7F, 24'hC00000, 1'b0, 3'b000, 32'h3FC00000, 2, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
